// File: rtl/divider_fixed_point_16_bit.sv
// Sequential sign-magnitude Q(N-Q-1).Q restoring divider, one quotient bit per clock.
// Define DIVIDER_ROUND_EN to compute a guard bit and round the magnitude half up.
module divider_fixed_point_16_bit #(
  parameter int unsigned N = 16,
  parameter int unsigned Q = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q_result,
  output logic         overflow,
  output logic         div_by_zero
);

`ifdef DIVIDER_ROUND_EN
  localparam int unsigned Iter = N + Q;
`else
  localparam int unsigned Iter = N - 1 + Q;
`endif
  // Dividend is |a| scaled so that Iter quotient bits carry the fractional (and guard) bits.
  localparam int unsigned Shift = Iter - (N - 1);
  localparam int unsigned CntW  = $clog2(Iter + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e            state_q;
  logic              sign_q;
  logic [Iter-1:0]   dvd_q;
  logic [Iter-1:0]   quot_q;
  logic [N-2:0]      dvs_q;
  logic [N-1:0]      rem_q;
  logic [CntW-1:0]   cnt_q;

  logic [N-2:0]      b_mag;
  logic [Iter-1:0]   dvd_load;
  logic [N-1:0]      rem_shift;
  logic [N-1:0]      rem_next;
  logic              ge;
  logic [Iter-1:0]   quot_next;
  logic [Iter-1:0]   mag_full;
  logic              mag_ovf;
  logic [N-2:0]      mag_final;

  always_comb begin
    b_mag     = b[N-2:0];
    dvd_load  = {a[N-2:0], {Shift{1'b0}}};
    rem_shift = {rem_q[N-2:0], dvd_q[Iter-1]};
    ge        = rem_shift >= {1'b0, dvs_q};
    rem_next  = ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    quot_next = {quot_q[Iter-2:0], ge};
`ifdef DIVIDER_ROUND_EN
    // Round half up; the extra top bit catches a carry that must saturate.
    mag_full  = {1'b0, quot_next[Iter-1:1]} + {{(Iter-1){1'b0}}, quot_next[0]};
`else
    mag_full  = quot_next;
`endif
    mag_ovf   = |mag_full[Iter-1:N-1];
    mag_final = mag_ovf ? {(N-1){1'b1}} : mag_full[N-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      dvd_q       <= '0;
      quot_q      <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q_result    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (start) begin
            if (b_mag == '0) begin
              state_q     <= StDone;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b1;
              q_result    <= {a[N-1], {(N-1){1'b1}}};
            end else begin
              state_q <= StDiv;
              busy    <= 1'b1;
              sign_q  <= a[N-1] ^ b[N-1];
              dvd_q   <= dvd_load;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              quot_q  <= '0;
              cnt_q   <= CntW'(Iter);
            end
          end
        end
        StDiv: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          dvd_q  <= {dvd_q[Iter-2:0], 1'b0};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            overflow    <= mag_ovf;
            div_by_zero <= 1'b0;
            // No negative zero on the output.
            q_result    <= {sign_q & (|mag_final), mag_final};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/divider_fixed_point_16_bit.md
Name: divider_fixed_point_16_bit

Overview:
- Sequential fixed-point divider; the inverse operation of the fixed-point multiplier.
- Uses the same sign-magnitude Q(N-Q-1).Q number format; with defaults this is Q3.12 in 16 bits.
- Computes q = a / b by restoring division, one quotient bit per clock, under a start/done handshake.
- Sits in the datapath alongside the multiplier wherever normalisation or reciprocal terms are needed.

Parameters:
- N, 16: total word width. Bit N-1 is the sign; bits N-2..0 are the magnitude.
- Q, 12: number of fractional bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled only in IDLE or DONE
- a  input  N  dividend, sign-magnitude
- b  input  N  divisor, sign-magnitude
- busy  output  1  high while in DIV state
- done  output  1  single-cycle pulse when the result is valid
- q_result  output  N  quotient, sign-magnitude; held until the next done
- overflow  output  1  quotient saturated; held with q_result
- div_by_zero  output  1  b magnitude was zero; held with q_result

Behaviour:
- Reset: asynchronous and active-low; one clock (clk) only.
- Reset values: state=IDLE; busy=0, done=0, q_result=0, overflow=0, div_by_zero=0; all internal registers cleared.
- ITER = N-1+Q iterations (27 with defaults).
- States: IDLE, DIV, DONE.
- IDLE/DONE to DIV, on start=1 with |b|!=0:
  - latch sign = a[N-1]^b[N-1];
  - load dividend shift register with |a|<<Q (N-1+Q bits);
  - load divisor |b|; clear partial remainder (N bits) and quotient;
  - load counter = ITER.
- IDLE/DONE to DONE, on start=1 with |b|==0:
  - div_by_zero=1, overflow=1;
  - q_result = {a[N-1], all ones}, i.e. saturated with the sign of a.
  - done pulses on the next cycle (latency 1).
- DIV, each clock:
  - rem = {rem, next dividend MSB};
  - if rem >= divisor: rem -= divisor and shift quotient bit 1; else shift 0;
  - decrement counter. On the cycle where the counter reaches 0, go to DONE.
- Entering DONE from DIV:
  - quotient magnitude is N-1+Q bits wide.
  - If any bit above N-2 is set: magnitude = all ones (2^(N-1)-1) and overflow=1.
  - Otherwise magnitude = low N-1 bits and overflow=0.
  - div_by_zero=0.
  - Sign bit forced to 0 when the final magnitude is 0 (no negative zero output).
- DONE lasts exactly one cycle with done=1, then returns to IDLE unless start=1 (see above).
- Latency: done is high in the cycle ITER+1 clocks after the accepting start edge (28 for defaults).
- busy: 1 exactly in DIV cycles; 0 in IDLE and DONE.
- start while busy=1 is ignored; a and b are not sampled.
- a and b are only sampled at the accepting edge; they may change freely afterwards.
- Reset asserted mid-division aborts immediately to reset values. No done is produced for the aborted operation.

Optional Feature:
- Macro: DIVIDER_ROUND_EN.
- Defined:
  - ITER = N+Q; one extra guard quotient bit is computed.
  - Final magnitude = (quotient>>1) + guard bit, i.e. round half up on magnitude.
  - A rounding carry beyond N-1 bits saturates and sets overflow.
  - Latency becomes N+Q+1 (29).
- Undefined: truncation toward zero; ITER = N-1+Q.

Test Plan:
- a=0x2000 (2.0), b=0x1000 (1.0), start pulse -> done exactly 28 clocks after the start edge; q_result=0x2000, overflow=0, div_by_zero=0; busy high for 27 cycles.
- a=0x2000, b=0x3000 (2/3) -> q_result=0x0AAA (truncated); with DIVIDER_ROUND_EN, q_result=0x0AAB after 29 clocks.
- Signs:
  - a=0x9000 (-1.0), b=0x2000 -> q_result=0x8800 (-0.5).
  - a=0x8000 (-0), b=0x1000 -> q_result=0x0000.
  - a=0x9000, b=0xA000 -> q_result=0x0800.
- Overflow:
  - a=0x7000 (7.0), b=0x0100 (0.0625) -> q_result=0x7FFF, overflow=1.
  - Same with b=0x8100 -> q_result=0xFFFF, overflow=1.
- Divide by zero: a=0x9000, b=0x8000 -> done one clock after start; q_result=0xFFFF, overflow=1, div_by_zero=1.
- Control:
  - Second start with different operands pulsed at cycle 5 of a division -> ignored; result matches the first operands.
  - Back-to-back: start held high through DONE -> new division accepted with no IDLE cycle.
  - rst_n pulsed low at cycle 10 -> all outputs 0 immediately; no done follows.
